floo_axi_burst_initiator: RTL and testbench

- Synthesizable AXI4 manager. It writes one INCR burst of a deterministic pattern, then reads the same burst back and checks it beat by beat.
- It is the initiator-side counterpart to the HBM subordinate models on the NoC borders. It attaches to a chimney's narrow or wide AXI manager port, or directly to an HBM model, for bring-up and self-test of compute tile arrays.
- Only one transaction is outstanding at a time. The write fully completes before the read starts.

---
 rtl/floo_burst_init_pkg.sv | 111 +++++++++++
 rtl/floo_axi_burst_initiator.sv | 181 ++++++++++++++++++
 tb/tb_floo_axi_burst_initiator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/floo_burst_init_pkg.sv
// Shared types and helpers for the AXI burst initiator: FSM encoding,
// AXI response/burst codes, default AXI channel structs and the beat pattern.
package floo_burst_init_pkg;

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_AW    = 3'd2;
  localparam state_t ST_W     = 3'd3;
  localparam state_t ST_B     = 3'd4;
  localparam state_t ST_AR    = 3'd5;
  localparam state_t ST_R     = 3'd6;
  localparam state_t ST_DONE  = 3'd7;

  // AXI response and burst codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Default (wide) channel geometry
  localparam int unsigned DefAddrW = 48;
  localparam int unsigned DefDataW = 512;
  localparam int unsigned DefIdW   = 3;
  localparam int unsigned DefUserW = 1;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [5:0]          atop;
    logic [DefUserW-1:0] user;
  } burst_axi_aw_t;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [DefUserW-1:0] user;
  } burst_axi_ar_t;

  typedef struct packed {
    logic [DefDataW-1:0]   data;
    logic [DefDataW/8-1:0] strb;
    logic                  last;
    logic [DefUserW-1:0]   user;
  } burst_axi_w_t;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [1:0]          resp;
    logic [DefUserW-1:0] user;
  } burst_axi_b_t;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [DefUserW-1:0] user;
  } burst_axi_r_t;

  typedef struct packed {
    burst_axi_aw_t aw;
    logic          aw_valid;
    burst_axi_w_t  w;
    logic          w_valid;
    logic          b_ready;
    burst_axi_ar_t ar;
    logic          ar_valid;
    logic          r_ready;
  } burst_axi_req_t;

  typedef struct packed {
    logic          aw_ready;
    logic          ar_ready;
    logic          w_ready;
    logic          b_valid;
    burst_axi_b_t  b;
    logic          r_valid;
    burst_axi_r_t  r;
  } burst_axi_rsp_t;

  // Beat idx of the pattern: 32-bit (seed + idx) replicated over data_width
  function automatic logic [1023:0] pattern_beat(input logic [31:0] seed,
                                                 input logic [7:0] idx,
                                                 input int unsigned data_width);
    logic [31:0] word;
    word = seed + {24'd0, idx};
    pattern_beat = '0;
    for (int unsigned i = 0; i < 32; i++)
      if (i < data_width / 32) pattern_beat[i*32 +: 32] = word;
  endfunction

endpackage

// File: rtl/floo_axi_burst_initiator.sv
// AXI4 self-test manager: writes one INCR burst of a seeded pattern, reads it
// back and counts failing beats. One transaction outstanding at a time.
module floo_axi_burst_initiator
  import floo_burst_init_pkg::*;
#(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 512,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned TxnId     = 0,
  parameter type axi_req_t = burst_axi_req_t,
  parameter type axi_rsp_t = burst_axi_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [7:0]           len_i,
  input  logic [31:0]          seed_i,
  output axi_req_t             axi_req_o,
  input  axi_rsp_t             axi_rsp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [8:0]           mismatch_cnt_o
);

  localparam int unsigned Bytes = DataWidth / 8;
  localparam int unsigned Size  = $clog2(Bytes);

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [31:0]          seed_q, seed_d;
  logic [7:0]           beat_q, beat_d;
  logic                 err_q, err_d;
  logic [8:0]           mis_q, mis_d;

  logic [DataWidth-1:0] beat_pat;
  logic                 last_beat;
  logic [16:0]          end_off;
  logic                 bad_start;
  logic                 r_fail;
  logic                 unused_rsp;

  assign beat_pat  = DataWidth'(pattern_beat(seed_q, beat_q, DataWidth));
  assign last_beat = (beat_q == len_q);

  // Burst must be size-aligned and must end at or before the 4 KiB page end
  assign end_off   = {5'd0, addr_q[11:0]} + ({9'd0, len_q} + 17'd1) * 17'(Bytes);
  assign bad_start = (|addr_q[Size-1:0]) || (end_off > 17'd4096);

  assign r_fail = (axi_rsp_i.r.data != beat_pat) ||
                  (axi_rsp_i.r.resp != RESP_OKAY) ||
                  (axi_rsp_i.r.id != IdWidth'(TxnId)) ||
                  (axi_rsp_i.r.last != last_beat);

  assign unused_rsp = ^{axi_rsp_i.b.user, axi_rsp_i.r.user};

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign error_o        = err_q;
  assign mismatch_cnt_o = mis_q;

  // Request channels: payload is zero except on the channel currently active
  always_comb begin
    axi_req_o = '0;
    case (state_q)
      ST_AW: begin
        axi_req_o.aw.id    = IdWidth'(TxnId);
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = len_q;
        axi_req_o.aw.size  = 3'(Size);
        axi_req_o.aw.burst = BURST_INCR;
        axi_req_o.aw.user  = UserWidth'(0);
        axi_req_o.aw_valid = 1'b1;
      end
      ST_W: begin
        axi_req_o.w.data  = beat_pat;
        axi_req_o.w.strb  = '1;
        axi_req_o.w.last  = last_beat;
        axi_req_o.w.user  = UserWidth'(0);
        axi_req_o.w_valid = 1'b1;
      end
      ST_B: axi_req_o.b_ready = 1'b1;
      ST_AR: begin
        axi_req_o.ar.id    = IdWidth'(TxnId);
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = len_q;
        axi_req_o.ar.size  = 3'(Size);
        axi_req_o.ar.burst = BURST_INCR;
        axi_req_o.ar.user  = UserWidth'(0);
        axi_req_o.ar_valid = 1'b1;
      end
      ST_R:    axi_req_o.r_ready = 1'b1;
      default: ;
    endcase
  end

  // Next-state: FSM sequencing, beat counting and readback checking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    seed_d  = seed_q;
    beat_d  = beat_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        addr_d  = base_addr_i;
        len_d   = len_i;
        seed_d  = seed_i;
        err_d   = 1'b0;
        mis_d   = '0;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bad_start) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_AW;
        end
      end
      ST_AW: if (axi_rsp_i.aw_ready) begin
        beat_d  = '0;
        state_d = ST_W;
      end
      ST_W: if (axi_rsp_i.w_ready) begin
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_B;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      ST_B: if (axi_rsp_i.b_valid) begin
        if (axi_rsp_i.b.resp != RESP_OKAY || axi_rsp_i.b.id != IdWidth'(TxnId))
          err_d = 1'b1;
        state_d = ST_AR;
      end
      ST_AR: if (axi_rsp_i.ar_ready) begin
        beat_d  = '0;
        state_d = ST_R;
      end
      ST_R: if (axi_rsp_i.r_valid) begin
        if (r_fail) begin
          err_d = 1'b1;
          if (mis_q != 9'd511) mis_d = mis_q + 9'd1;
        end
        if (last_beat) state_d = ST_DONE;
        else           beat_d  = beat_q + 8'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_floo_axi_burst_initiator.sv
// Randomized bench for the burst initiator with an in-bench AXI memory
// subordinate (backpressure, SLVERR and readback corruption knobs).
module tb_floo_axi_burst_initiator;
  import floo_burst_init_pkg::*;

  localparam int BY = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [47:0]    base;
  logic [7:0]     len;
  logic [31:0]    seed;
  burst_axi_req_t req;
  burst_axi_rsp_t rsp;
  logic           busy, done, err;
  logic [8:0]     mis;

  always #5 clk = ~clk;

  floo_axi_burst_initiator dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
    .len_i(len), .seed_i(seed), .axi_req_o(req), .axi_rsp_i(rsp),
    .busy_o(busy), .done_o(done), .error_o(err), .mismatch_cnt_o(mis)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- subordinate model ----------------
  logic [511:0]   mem [logic [47:0]];
  logic [511:0]   wlog [$];
  bit             sl_slverr, sl_bp;
  logic [255:0]   sl_corrupt;
  int             hold, aw_cycles, w_early;
  bit             aw_got, b_pend, ar_got;
  logic [47:0]    w_addr, r_addr;
  logic [7:0]     r_len;
  logic [2:0]     aw_id, ar_id;
  int             wcnt, rcnt;
  burst_axi_req_t p_req;

  function automatic bit rdy();
    if (sl_bp) return (hold >= 5) && ($urandom_range(0, 1) == 1);
    return $urandom_range(0, 3) != 0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      rsp = '0; p_req = '0; aw_got = 0; b_pend = 0; ar_got = 0;
      wcnt = 0; rcnt = 0; hold = 0;
    end else begin
      bit r_hs;
      hold++;
      // payload stability while stalled
      if (p_req.aw_valid && !rsp.aw_ready)
        chk("aw_stable", 64'(req.aw_valid && req.aw == p_req.aw), 1);
      if (p_req.ar_valid && !rsp.ar_ready)
        chk("ar_stable", 64'(req.ar_valid && req.ar == p_req.ar), 1);
      if (p_req.w_valid && !rsp.w_ready)
        chk("w_stable", 64'(req.w_valid && req.w == p_req.w), 1);
      // retire handshakes of the previous posedge
      if (p_req.aw_valid && rsp.aw_ready) begin
        aw_got = 1; w_addr = p_req.aw.addr; aw_id = p_req.aw.id; wcnt = 0; hold = 0;
      end
      if (p_req.w_valid && rsp.w_ready) begin
        mem[w_addr + 48'(wcnt * BY)] = p_req.w.data;
        wlog.push_back(p_req.w.data);
        wcnt++; hold = 0;
        if (p_req.w.last) b_pend = 1;
      end
      if (rsp.b_valid && p_req.b_ready) begin b_pend = 0; aw_got = 0; end
      if (p_req.ar_valid && rsp.ar_ready) begin
        ar_got = 1; r_addr = p_req.ar.addr; r_len = p_req.ar.len; ar_id = p_req.ar.id;
        rcnt = 0; hold = 0;
      end
      r_hs = rsp.r_valid && p_req.r_ready;
      if (r_hs) begin
        rcnt++;
        if (rcnt > int'(r_len)) ar_got = 0;
      end
      if (req.w_valid && !aw_got) w_early++;
      if (req.aw_valid) aw_cycles++;
      // drive the next cycle
      rsp.aw_ready = rdy();
      rsp.w_ready  = aw_got && rdy();
      rsp.ar_ready = rdy();
      rsp.b_valid  = b_pend && !aw_got ? 1'b0 : b_pend && (rsp.b_valid || $urandom_range(0, 1) == 1);
      rsp.b.id     = aw_id;
      rsp.b.resp   = sl_slverr ? RESP_SLVERR : RESP_OKAY;
      rsp.b.user   = '0;
      if (ar_got) begin
        logic [47:0] a;
        a = r_addr + 48'(rcnt * BY);
        rsp.r_valid  = (rsp.r_valid && !r_hs) || ($urandom_range(0, 2) != 0);
        rsp.r.data   = mem.exists(a) ? mem[a] : '0;
        rsp.r.data[0] = rsp.r.data[0] ^ sl_corrupt[rcnt];
        rsp.r.id     = ar_id;
        rsp.r.resp   = RESP_OKAY;
        rsp.r.last   = (rcnt == int'(r_len));
        rsp.r.user   = '0;
      end else begin
        rsp.r_valid = 1'b0;
        rsp.r       = '0;
      end
      p_req = req;
    end
  end

  // ---------------- one burst vs. reference ----------------
  task automatic run(input logic [47:0] b, input logic [7:0] l, input logic [31:0] s,
                     input bit slverr, input logic [255:0] corrupt, input bit bp,
                     input bit noise);
    bit rej, exp_err;
    int exp_mis, lat, awlat, ndone, extra;
    logic [511:0] e;
    rej = (b[5:0] != 6'd0) || (int'(b[11:0]) + (int'(l) + 1) * BY > 4096);
    exp_mis = 0;
    if (!rej) for (int i = 0; i <= int'(l); i++) if (corrupt[i]) exp_mis++;
    exp_err = rej || slverr || (exp_mis > 0);
    sl_slverr = slverr; sl_corrupt = corrupt; sl_bp = bp;
    wlog.delete(); aw_cycles = 0; w_early = 0;
    @(negedge clk); start = 1; base = b; len = l; seed = s;
    @(negedge clk); start = 0;
    lat = 1; awlat = -1; ndone = 0;
    for (int c = 0; c < 5000; c++) begin
      if (req.aw_valid && awlat < 0) awlat = lat;
      if (done) begin ndone = 1; break; end
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1; base = {$urandom, $urandom}; len = 8'($urandom); seed = $urandom;
      end else start = 0;
      @(negedge clk); lat++;
    end
    if (ndone == 0) chk("done_timeout", 0, 1);
    chk("error", 64'(err), 64'(exp_err));
    chk("mismatch", 64'(mis), 64'(exp_mis));
    if (rej) begin
      chk("rej_latency", 64'(lat), 2);
      chk("rej_aw_cycles", 64'(aw_cycles), 0);
    end else begin
      chk("aw_latency", 64'(awlat), 2);
      chk("w_before_aw", 64'(w_early), 0);
      chk("w_beats", 64'(wlog.size()), 64'(int'(l) + 1));
      for (int i = 0; i < wlog.size() && i <= int'(l); i++) begin
        for (int k = 0; k < 16; k++) e[k*32 +: 32] = s + 32'(i);
        chk("wdata", 64'(wlog[i] == e), 1);
      end
    end
    // start coinciding with the done pulse must be ignored
    start = noise;
    @(negedge clk); start = 0;
    chk("busy_after_done", 64'(busy), 0);
    extra = 0;
    repeat (3) begin if (done) extra++; @(negedge clk); end
    chk("extra_done", 64'(extra), 0);
  endtask

  initial begin
    logic [47:0] rb;
    logic [7:0]  rl;
    rst = 1; start = 0; base = '0; len = '0; seed = '0;
    sl_slverr = 0; sl_bp = 0; sl_corrupt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(err), 0);
    chk("rst_mis", 64'(mis), 0);
    chk("rst_req_zero", 64'(req == '0), 1);
    #2 rst = 0;

    run(48'h8000_0000, 8'd3, 32'hA5A5_0000, 0, '0, 0, 0);
    chk("last_word", 64'(wlog.size() == 4 ? wlog[3][31:0] : 32'd0), 64'h0000_0000_A5A5_0003);
    run(48'h8000_1000, 8'd0, $urandom, 0, '0, 0, 0);
    run(48'h40, 8'd63, 32'h1, 0, '0, 0, 0);          // 4 KiB crossing
    run(48'h8, 8'd0, 32'h2, 0, '0, 0, 0);            // misaligned
    run(48'h1C00, 8'd15, $urandom, 0, '0, 0, 0);     // ends exactly on page end
    run(48'h1C40, 8'd15, $urandom, 0, '0, 0, 0);     // one beat past page end
    run(48'h2000, 8'd255, $urandom, 0, '0, 0, 0);    // 256 beats never fit
    run(48'h3000, 8'd3, $urandom, 0, 256'b0110, 0, 0);
    run(48'h4000, 8'd3, $urandom, 1, '0, 0, 0);
    run(48'h5000, 8'd15, $urandom, 0, '0, 1, 0);
    run(48'h6000, 8'd7, $urandom, 0, '0, 1, 1);

    // reset in the middle of W
    sl_slverr = 0; sl_corrupt = '0; sl_bp = 0; wlog.delete();
    @(negedge clk); start = 1; base = 48'h7000; len = 8'd7; seed = $urandom;
    @(negedge clk); start = 0;
    for (int c = 0; c < 200 && wlog.size() < 2; c++) @(negedge clk);
    chk("mid_w", 64'(req.w_valid), 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_valids", 64'({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_req_zero", 64'(req == '0), 1);
    #2 rst = 0;
    run(48'h7000, 8'd7, $urandom, 0, '0, 0, 0);

    // random bursts
    for (int t = 0; t < 10; t++) begin
      rb = {16'($urandom), 20'($urandom), 12'($urandom_range(0, 63) * 64)};
      if ($urandom_range(0, 5) == 0) rb[5:0] = 6'($urandom_range(1, 63));
      rl = 8'($urandom_range(0, 40));
      run(rb, rl, $urandom, $urandom_range(0, 4) == 0,
          {224'd0, 32'($urandom) & 32'($urandom)}, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
